// File: rtl/bus_wrr_sched.sv
// Weighted round-robin pop scheduler for the shared bus generator/arbiter datapath.
// Optional starvation monitor is built only when WRR_STARVE_MON_EN is defined.

`ifdef WRR_STARVE_MON_EN
module bus_wrr_starve_cnt #(
    parameter int LIM = 256
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pndng,
    input  logic i_gnt,
    output logic o_starve
);
    localparam int CW = $clog2(LIM + 1);

    logic [CW-1:0] r_cnt;
    logic          w_wait;

    assign w_wait = i_pndng && !i_gnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            o_starve <= 1'b0;
        end else begin
            if (!w_wait)
                r_cnt <= '0;
            else if (r_cnt != CW'(LIM))
                r_cnt <= r_cnt + 1'b1;
            if (w_wait && r_cnt == CW'(LIM - 1))
                o_starve <= 1'b1;
        end
    end
endmodule
`endif

module bus_wrr_sched #(
    parameter  int DRVS     = 8,
    parameter  int WGT_W    = 4,
    parameter  int TMO      = 64,
    parameter  int STRV_LIM = 256,
    localparam int ID_W     = (DRVS > 1) ? $clog2(DRVS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DRVS-1:0]       i_pndng,
    input  logic [DRVS*WGT_W-1:0] i_weights,
    input  logic                  i_xfer_done,
    output logic [DRVS-1:0]       o_pop,
    output logic [DRVS-1:0]       o_gnt,
    output logic [ID_W-1:0]       o_gnt_id,
    output logic                  o_busy,
    output logic                  o_tmo_err,
    output logic [DRVS-1:0]       o_starve
);
    localparam int              TW  = $clog2(TMO + 1);
    localparam logic [DRVS-1:0] ONE = 1;

    if (TMO < 2 || STRV_LIM < 2) begin : g_param_chk
        $error("bus_wrr_sched: TMO and STRV_LIM must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT} state_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WGT_W-1:0] wgt;
        logic [WGT_W-1:0] cnt;
    } gnt_t;

    state_t           r_state, w_state_nxt;
    gnt_t             r_cur, w_cur_nxt;
    logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
    logic [TW-1:0]    r_tmr, w_tmr_nxt;
    logic [DRVS-1:0]  r_pop, w_pop_nxt;
    logic [DRVS-1:0]  r_gnt, w_gnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_tmo_err, w_tmo_err_nxt;

    logic [WGT_W-1:0] w_wgt [DRVS];
    logic [DRVS-1:0]  w_starve;
    logic             w_arb_hit;
    logic [ID_W-1:0]  w_arb_id, w_scan_id;
    logic             w_more;
    logic             w_end, w_adv;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= DRVS)
            s = s - DRVS;
        return ID_W'(s);
    endfunction

    for (genvar i = 0; i < DRVS; i++) begin : g_wgt
        assign w_wgt[i] = i_weights[i*WGT_W +: WGT_W];
    end

`ifdef WRR_STARVE_MON_EN
    for (genvar i = 0; i < DRVS; i++) begin : g_strv
        bus_wrr_starve_cnt #(.LIM(STRV_LIM)) u_cnt (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_pndng (i_pndng[i]),
            .i_gnt   (r_gnt[i]),
            .o_starve(w_starve[i])
        );
    end
`else
    assign w_starve = '0;
`endif

    // Scan backwards so the last hit is the first pending driver at or after ptr.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_id  = '0;
        w_scan_id = '0;
        for (int k = DRVS - 1; k >= 0; k--) begin
            w_scan_id = wrap_inc(r_ptr, k);
            if (i_pndng[w_scan_id]) begin
                w_arb_hit = 1'b1;
                w_arb_id  = w_scan_id;
            end
        end
`ifdef WRR_STARVE_MON_EN
        for (int i = DRVS - 1; i >= 0; i--) begin
            if (w_starve[i] && i_pndng[i]) begin
                w_arb_hit = 1'b1;
                w_arb_id  = ID_W'(i);
            end
        end
`endif
    end

    assign w_more = ({1'b0, r_cur.cnt} + 1'b1) < {1'b0, r_cur.wgt};

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_ptr_nxt     = r_ptr;
        w_tmr_nxt     = r_tmr;
        w_pop_nxt     = '0;
        w_gnt_nxt     = r_gnt;
        w_busy_nxt    = r_busy;
        w_tmo_err_nxt = 1'b0;
        w_end         = 1'b0;
        w_adv         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_arb_hit) begin
                    w_cur_nxt.id  = w_arb_id;
                    w_cur_nxt.wgt = (w_wgt[w_arb_id] == '0) ? WGT_W'(1) : w_wgt[w_arb_id];
                    w_cur_nxt.cnt = '0;
                    w_gnt_nxt     = ONE << w_arb_id;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_POP;
                end
            end
            S_POP: begin
                // A FIFO that emptied before its pop loses the grant but keeps its turn.
                if (i_pndng[r_cur.id]) begin
                    w_pop_nxt   = ONE << r_cur.id;
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_end = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_xfer_done) begin
                    if (w_more && i_pndng[r_cur.id]) begin
                        w_cur_nxt.cnt = r_cur.cnt + 1'b1;
                        w_state_nxt   = S_POP;
                    end else begin
                        w_end = 1'b1;
                        w_adv = 1'b1;
                    end
                end else if (r_tmr == TW'(TMO - 1)) begin
                    w_tmo_err_nxt = 1'b1;
                    w_end         = 1'b1;
                    w_adv         = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_adv)
            w_ptr_nxt = wrap_inc(r_cur.id, 1);
        if (w_end) begin
            w_cur_nxt   = '0;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_ptr     <= '0;
            r_tmr     <= '0;
            r_pop     <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_ptr     <= w_ptr_nxt;
            r_tmr     <= w_tmr_nxt;
            r_pop     <= w_pop_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= w_busy_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    assign o_pop     = r_pop;
    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_cur.id;
    assign o_busy    = r_busy;
    assign o_tmo_err = r_tmo_err;
    assign o_starve  = w_starve;

endmodule

// File: tb/tb_bus_wrr_sched.sv
// Randomised bench for bus_wrr_sched: the bench plays the datapath and predicts
// each grant from a transaction-level WRR model (pointer, weight, burst count).
module tb_bus_wrr_sched;
    localparam int DRVS  = 8;
    localparam int WGT_W = 4;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pndng;
    logic [31:0] weights;
    logic        xfer_done;
    logic [7:0]  pop, gnt, starve;
    logic [2:0]  gnt_id;
    logic        busy, tmo_err;

    int n_chk  = 0;
    int n_pass = 0;
    int mptr   = 0;
    int dly_fix = -1, dly_max = 2, p_tmo = 0, p_drop = 0, p_spur = 0;
    bit rnd_w = 1'b0;

    bus_wrr_sched #(.DRVS(DRVS), .WGT_W(WGT_W), .TMO(TMO), .STRV_LIM(256)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_pndng    (pndng),
        .i_weights  (weights),
        .i_xfer_done(xfer_done),
        .o_pop      (pop),
        .o_gnt      (gnt),
        .o_gnt_id   (gnt_id),
        .o_busy     (busy),
        .o_tmo_err  (tmo_err),
        .o_starve   (starve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int pick(input int ptr, input logic [7:0] pnd);
        for (int k = 0; k < DRVS; k++)
            if (pnd[(ptr + k) % DRVS]) return (ptr + k) % DRVS;
        return -1;
    endfunction

    function automatic int wgt_of(input logic [31:0] w, input int g);
        int v;
        v = int'((w >> (g * WGT_W)) & 32'hF);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Entered at the negedge of an idle cycle with pndng already driven;
    // leaves at the negedge of the next idle cycle.
    task automatic grant_once();
        int g, wg, n, d;
        bit pop_ok, cont, fin;
        logic [7:0] oh;
        g = pick(mptr, pndng);
        if (roll(p_spur)) xfer_done = 1'b1;
        cyc();
        xfer_done = 1'b0;
        if (g < 0) begin
            chk("idle", {14'b0, tmo_err, busy, pop, gnt}, 32'h0);
            return;
        end
        wg = wgt_of(weights, g);
        oh = 8'h1 << g;
        chk("gnt", {20'b0, busy, gnt_id, gnt}, {20'b0, 1'b1, 3'(g), oh});
        chk("pre_pop", {23'b0, tmo_err, pop}, 32'h0);
        if (rnd_w) weights = $urandom();
        n = 0;
        fin = 1'b0;
        while (!fin) begin
            if (roll(p_drop)) pndng[g] = 1'b0;
            if (roll(p_spur)) xfer_done = 1'b1;
            pop_ok = pndng[g];
            cyc();
            xfer_done = 1'b0;
            if (!pop_ok) begin
                chk("no_pop", {15'b0, busy, pop, gnt}, 32'h0);
                fin = 1'b1;
            end else begin
                chk("pop", {15'b0, busy, pop, gnt}, {15'b0, 1'b1, oh, oh});
                n++;
                if (roll(p_tmo)) begin
                    for (int j = 1; j < TMO; j++) begin
                        cyc();
                        chk("tmo_wait", {15'b0, tmo_err, pop, gnt}, {24'b0, oh});
                    end
                    cyc();
                    chk("tmo", {22'b0, tmo_err, busy, gnt}, {22'b0, 1'b1, 1'b0, 8'h0});
                    mptr = (g + 1) % DRVS;
                    fin  = 1'b1;
                end else begin
                    d = (dly_fix >= 0) ? dly_fix : int'($urandom_range(dly_max));
                    for (int j = 0; j < d; j++) begin
                        cyc();
                        chk("wait", {16'b0, pop, gnt}, {24'b0, oh});
                        if (roll(p_drop / 2)) pndng[g] = 1'b0;
                    end
                    xfer_done = 1'b1;
                    if (roll(p_drop)) pndng[g] = 1'b0;
                    cont = (n < wg) && pndng[g];
                    cyc();
                    xfer_done = 1'b0;
                    if (cont) begin
                        chk("burst", {15'b0, busy, pop, gnt}, {15'b0, 1'b1, 8'h0, oh});
                    end else begin
                        chk("rel", {22'b0, tmo_err, busy, gnt}, 32'h0);
                        mptr = (g + 1) % DRVS;
                        fin  = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        pndng     = 8'h00;
        weights   = 32'h1111_1111;
        xfer_done = 1'b0;
        repeat (3) cyc();
        chk("reset", {3'b0, starve, tmo_err, busy, gnt_id, gnt, pop}, 32'h0);
        rst = 1'b0;

        // single driver, fixed datapath latency, pointer wraps back to 0
        pndng = 8'h01; dly_fix = 3;
        repeat (3) grant_once();

        // all pending, unit weights: full rotation
        pndng = 8'hFF; dly_fix = -1;
        repeat (9) grant_once();

        // driver 3 bursts three packets
        weights = 32'h1111_3111;
        repeat (4) grant_once();

        // zero weight on driver 2 acts as one
        weights = 32'h1111_1011;
        repeat (6) grant_once();

        // timeout then recovery to the next pending driver
        weights = 32'h1111_1111;
        p_tmo = 100; grant_once();
        p_tmo = 0;   grant_once();

        // reset in WAIT with driver 4 granted; pointer must restart at 0
        pndng = 8'h20; grant_once();
        pndng = 8'h10;
        cyc(); cyc(); cyc();
        chk("pre_rst_gnt", {24'b0, gnt}, 32'h10);
        #2 rst = 1'b1;
        #1 chk("rst_async", {3'b0, starve, tmo_err, busy, gnt_id, gnt, pop}, 32'h0);
        mptr = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        cyc();
        pndng = 8'h90;
        grant_once();

        // randomised traffic
        rnd_w = 1'b1; dly_max = 4; p_tmo = 3; p_drop = 10; p_spur = 10;
        repeat (200) begin
            pndng   = roll(15) ? 8'h00 : 8'($urandom());
            weights = $urandom();
            grant_once();
        end
        chk("starve_off", {24'b0, starve}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_wrr_sched.md
Name: bus_wrr_sched

Overview:
- Weighted round-robin scheduler that sequences source-side pops for the shared bus generator/arbiter datapath.
- Watches each driver FIFO's pndng and grants the bus to one driver at a time.
- Issues a single-cycle pop to the granted driver, then waits for the datapath's transfer-done pulse.
- A granted driver may send up to its configured weight of back-to-back packets before the grant rotates.

Parameters:
DRVS, 8, number of driver FIFOs sharing the bus
WGT_W, 4, width of each per-driver weight field
TMO, 64, max cycles to wait for xfer_done before aborting a grant
STRV_LIM, 256, starvation threshold in cycles (used only with optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pndng  in  DRVS  per-driver "FIFO not empty" flags
weights  in  DRVS*WGT_W  packed per-driver weights; field i = bits [i*WGT_W +: WGT_W]; sampled at grant time
xfer_done  in  1  one-cycle pulse from datapath: popped packet fully delivered
pop  out  DRVS  one-hot single-cycle pop strobe to granted driver FIFO
gnt  out  DRVS  one-hot grant vector, held for whole grant
gnt_id  out  $clog2(DRVS)  binary index of granted driver
busy  out  1  high while any grant is active
tmo_err  out  1  one-cycle pulse when a TMO abort occurs
starve  out  DRVS  sticky per-driver starvation flags (optional feature only; else tied 0)

Behaviour:
- All outputs are registered.
- Reset values: pop=0, gnt=0, gnt_id=0, busy=0, tmo_err=0, starve=0; internal ptr=0, burst count=0, FSM=IDLE.
- Reset asserted mid-transfer aborts immediately. No pop is issued after reset deassertion until a fresh arbitration.
- FSM states: IDLE, POP, WAIT.
- IDLE:
  - If pndng==0, stay in IDLE.
  - Otherwise select the first i with pndng[i]=1, scanning circularly from ptr (ptr, ptr+1, ..., wrapping at DRVS-1 -> 0).
  - Latch g=i and its weight wg; a weight of 0 is treated as 1.
  - Set gnt/gnt_id/busy on the next edge and go to POP.
- POP:
  - pop[g]=1 for exactly one cycle; go to WAIT.
  - Latency: pndng rising at edge k -> gnt at edge k+1 -> pop high during cycle k+2.
- WAIT:
  - Count cycles; cnt increments on xfer_done.
  - On xfer_done with cnt+1 < wg and pndng[g]=1: keep the grant, go to POP next cycle (burst continues).
  - On xfer_done otherwise: ptr = (g+1) mod DRVS, cnt=0, drop gnt/busy, go to IDLE.
  - If TMO cycles elapse without xfer_done: pulse tmo_err, advance ptr as above, go to IDLE.
  - xfer_done seen in IDLE or POP is ignored.
- pndng[g] falling during WAIT does not cancel the outstanding transfer.
- Minimum gap between grants to different drivers is 1 idle cycle (the IDLE arbitration cycle).
- At most one pop bit is ever high; pop is never asserted while pndng[g]=0 at the POP cycle. In that case, go to IDLE without popping or advancing ptr.

Optional Feature:
- Macro: WRR_STARVE_MON_EN.
- Defined:
  - Per-driver wait counter increments each cycle pndng[i]=1 and gnt[i]=0; it clears on grant to i or when pndng[i]=0.
  - When a counter reaches STRV_LIM, starve[i] sets and stays set until reset.
  - While any starve bit is set, IDLE picks the lowest-index starving, pending driver ahead of the round-robin scan.
- Undefined: no counters are synthesised, starve is tied to 0, and arbitration is pure weighted round-robin.

Test Plan:
- pndng=8'h01, weights all 1, xfer_done 3 cycles after each pop -> pop=8'h01 in cycle 2; grant releases and re-grants driver 0 after each done; ptr wraps correctly.
- pndng=8'hFF held, all weights=1 -> grant order 0,1,2,...,7,0; exactly one pop per grant; gnt_id matches gnt.
- Driver 3 weight=3, others 1, all pending -> driver 3 gets three consecutive pops with no IDLE gap between them; then driver 4 is granted.
- Weight field=0 for driver 2 -> behaves as weight 1: one pop, then the grant rotates.
- Granted driver with no xfer_done for 64 cycles -> tmo_err is a single pulse; gnt clears; the next pending driver is granted.
- Reset asserted while in WAIT with gnt=8'h10 -> all outputs 0 asynchronously; after release with pndng=8'h10, scan restarts from ptr=0 and driver 4 is granted.
